// File: rtl/ras_link_stack.sv
// ras_link_stack: linked-list return-address stack in front of a node allocator.
// Each push takes one node from the allocator and links it to the previous top.
// Each pop hands the top node back to the allocator.
// The top-of-stack word is held in registers, so pop_data needs no RAM access.
// Optional feature macro: RAS_FLUSH_EN. It adds a flush input that empties the
// stack and restarts the allocator.
module ras_link_stack #(
  parameter int unsigned ADDR       = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef RAS_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             alloc,
  output logic             de_alloc,
  output logic [ADDR-1:0]  last_alloc_addr,
  input  logic [ADDR-1:0]  alloc_addr,
  output logic             alloc_reset,
  output logic [ADDR-1:0]  alloc_reset_addr
);

  localparam int unsigned CW = ADDR + 1;

  typedef enum logic [1:0] {INIT0, INIT1, READY, FETCH} state_e;

  state_e             state_q, state_d;
  logic [ADDR-1:0]    tos_addr_q, tos_addr_d;
  logic [ADDR-1:0]    tos_prev_q, tos_prev_d;
  logic [WIDTH-1:0]   tos_data_q, tos_data_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  // Node storage: data and back-pointer are separate so a top replace can
  // rewrite the data without touching the link.
  logic [WIDTH-1:0]   node_data_q [DEPTH];
  logic [ADDR-1:0]    node_prev_q [DEPTH];
  logic [WIDTH-1:0]   rd_data_q;
  logic [ADDR-1:0]    rd_prev_q;

  logic               wr_data_en, wr_link_en, rd_en;
  logic [ADDR-1:0]    wr_addr, rd_addr;
  logic               flush_req;
  logic               empty_c, full_c;

`ifdef RAS_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign empty_c          = (count_q == CW'(0));
  assign full_c           = (count_q == CW'(DEPTH));
  assign empty            = empty_c;
  assign full             = full_c;
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign pop_data         = tos_data_q;
  assign ready            = (state_q == READY) && !reset;
  assign alloc_reset      = reset | flush_req;
  assign alloc_reset_addr = ADDR'(RESET_ADDR);

  // Next-state, stack pointer update and allocator handshake.
  always_comb begin
    state_d         = state_q;
    tos_addr_d      = tos_addr_q;
    tos_prev_d      = tos_prev_q;
    tos_data_d      = tos_data_q;
    count_d         = count_q;
    overflow_d      = 1'b0;
    underflow_d     = 1'b0;
    alloc           = 1'b0;
    de_alloc        = 1'b0;
    last_alloc_addr = tos_addr_q;
    wr_data_en      = 1'b0;
    wr_link_en      = 1'b0;
    wr_addr         = alloc_addr;
    rd_en           = 1'b0;
    rd_addr         = tos_prev_q;

    if (reset || flush_req) begin
      state_d    = INIT0;
      tos_addr_d = '0;
      tos_prev_d = '0;
      tos_data_d = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        INIT0: state_d = INIT1;
        INIT1: state_d = READY;
        FETCH: begin
          tos_data_d = rd_data_q;
          tos_prev_d = rd_prev_q;
          state_d    = READY;
        end
        READY: begin
          if (push && pop && !empty_c) begin
            // Replace top in place: no node changes hands.
            tos_data_d = push_data;
            wr_data_en = 1'b1;
            wr_addr    = tos_addr_q;
          end else if (push) begin
            if (full_c) begin
              overflow_d = 1'b1;
            end else begin
              alloc      = 1'b1;
              wr_data_en = 1'b1;
              wr_link_en = 1'b1;
              wr_addr    = alloc_addr;
              tos_prev_d = tos_addr_q;
              tos_addr_d = alloc_addr;
              tos_data_d = push_data;
              count_d    = count_q + CW'(1);
            end
          end else if (pop) begin
            if (empty_c) begin
              underflow_d = 1'b1;
            end else begin
              de_alloc   = 1'b1;
              tos_addr_d = tos_prev_q;
              count_d    = count_q - CW'(1);
              rd_en      = 1'b1;
              rd_addr    = tos_prev_q;
              state_d    = FETCH;
            end
          end
        end
        default: state_d = INIT0;
      endcase
    end
  end

  // Control and top-of-stack registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT0;
      tos_addr_q  <= '0;
      tos_prev_q  <= '0;
      tos_data_q  <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tos_addr_q  <= tos_addr_d;
      tos_prev_q  <= tos_prev_d;
      tos_data_q  <= tos_data_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Node RAM: synchronous write, registered read.
  always_ff @(posedge clk) begin
    if (wr_data_en) node_data_q[wr_addr] <= push_data;
    if (wr_link_en) node_prev_q[wr_addr] <= tos_addr_q;
    if (rd_en) begin
      rd_data_q <= node_data_q[rd_addr];
      rd_prev_q <= node_prev_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_ras_link_stack.sv
// Bench for ras_link_stack (DEPTH=4) with a LIFO allocator model and a pop scoreboard.
module tb_ras_link_stack;

  localparam int unsigned ADDR  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             ready;
  logic [WIDTH-1:0] pop_data;
  logic             empty;
  logic             full;
  logic [ADDR:0]    count;
  logic             overflow;
  logic             underflow;
  logic             alloc;
  logic             de_alloc;
  logic [ADDR-1:0]  last_alloc_addr;
  logic [ADDR-1:0]  alloc_addr;
  logic             alloc_reset;
  logic [ADDR-1:0]  alloc_reset_addr;
`ifdef RAS_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: model stack of pushed values and their nodes, plus expected pops.
  logic [WIDTH-1:0] model_data [$];
  logic [ADDR-1:0]  model_addr [$];
  logic [WIDTH-1:0] exp_data   [$];
  logic [ADDR-1:0]  exp_addr   [$];

  ras_link_stack #(.ADDR(ADDR), .DEPTH(DEPTH), .WIDTH(WIDTH), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset),
`ifdef RAS_FLUSH_EN
    .flush(flush),
`endif
    .push(push), .push_data(push_data), .pop(pop), .ready(ready),
    .pop_data(pop_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .alloc(alloc),
    .de_alloc(de_alloc), .last_alloc_addr(last_alloc_addr),
    .alloc_addr(alloc_addr), .alloc_reset(alloc_reset),
    .alloc_reset_addr(alloc_reset_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LIFO allocator model: freed nodes are handed out again first.
  logic [ADDR-1:0] free_stk [DEPTH];
  logic [ADDR:0]   sp;
  always @(posedge clk) begin
    if (alloc_reset) begin
      for (int i = 0; i < DEPTH; i++) free_stk[i] <= ADDR'(i);
      sp <= '0;
    end else if (alloc) begin
      sp <= sp + 1'b1;
    end else if (de_alloc) begin
      sp <= sp - 1'b1;
      free_stk[ADDR'(sp - 1'b1)] <= last_alloc_addr;
    end
  end
  assign alloc_addr = free_stk[ADDR'(sp)];

  task automatic drive(input logic p, input logic [WIDTH-1:0] d, input logic q);
    @(negedge clk);
    push = p; push_data = d; pop = q;
    #1;
  endtask

  task automatic sb_push(input logic [WIDTH-1:0] d);
    model_data.push_back(d);
    model_addr.push_back(alloc_addr);
  endtask

  task automatic sb_pop();
    exp_data.push_back(model_data.pop_back());
    exp_addr.push_back(model_addr.pop_back());
  endtask

  task automatic sb_clear();
    model_data.delete(); model_addr.delete(); exp_data.delete(); exp_addr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
`ifdef RAS_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    checks++; if (alloc_reset !== 1'b1) begin errors++; $display("FAIL rst_alloc_reset: got %b want 1", alloc_reset); end
    checks++; if (alloc_reset_addr !== 2'd0) begin errors++; $display("FAIL rst_alloc_reset_addr: got %0d want 0", alloc_reset_addr); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_count: got %0d/%b want 0/1", count, empty); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || alloc !== 1'b0 || de_alloc !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got %b%b%b%b want 0000", overflow, underflow, alloc, de_alloc); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (ready !== 1'b0 || alloc_reset !== 1'b0) begin errors++; $display("FAIL rel_cycle1: ready %b alloc_reset %b want 0 0", ready, alloc_reset); end
    drive(0, '0, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rel_cycle2: ready %b want 0", ready); end
    drive(0, '0, 0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rel_cycle3: ready %b want 1", ready); end
    sb_clear();
  endtask

  task automatic test_push3();
    for (int i = 0; i < 3; i++) begin
      drive(1, WIDTH'(32'hA0 + i), 0);
      checks++; if (ready !== 1'b1 || alloc !== 1'b1 || de_alloc !== 1'b0) begin
        errors++; $display("FAIL push3_alloc[%0d]: ready %b alloc %b de_alloc %b want 1 1 0", i, ready, alloc, de_alloc); end
      checks++; if (count !== 3'(i)) begin errors++; $display("FAIL push3_count[%0d]: got %0d want %0d", i, count, i); end
      sb_push(WIDTH'(32'hA0 + i));
    end
    drive(0, '0, 0);
    checks++; if (count !== 3'd3 || empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL push3_final: count %0d empty %b full %b want 3 0 0", count, empty, full); end
    checks++; if (pop_data !== 32'hA2) begin errors++; $display("FAIL push3_top: got %0h want a2", pop_data); end
    checks++; if (dut.node_prev_q[2] !== 2'd1 || dut.node_prev_q[1] !== 2'd0) begin
      errors++; $display("FAIL push3_links: 2->%0d 1->%0d want 2->1 1->0", dut.node_prev_q[2], dut.node_prev_q[1]); end
  endtask

  // Pop n entries, checking each against the scoreboard and the FETCH bubble.
  task automatic test_pop_n(input int n, input string tag);
    logic [WIDTH-1:0] ed;
    logic [ADDR-1:0]  ea;
    for (int i = 0; i < n; i++) begin
      drive(0, '0, 1);
      sb_pop();
      ed = exp_data.pop_front();
      ea = exp_addr.pop_front();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready[%0d]: got %b want 1", tag, i, ready); end
      checks++; if (pop_data !== ed) begin errors++; $display("FAIL %s_data[%0d]: got %0h want %0h", tag, i, pop_data, ed); end
      checks++; if (de_alloc !== 1'b1 || alloc !== 1'b0 || last_alloc_addr !== ea) begin
        errors++; $display("FAIL %s_dealloc[%0d]: de_alloc %b alloc %b addr %0d want 1 0 %0d", tag, i, de_alloc, alloc, last_alloc_addr, ea); end
      drive(0, '0, 0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL %s_fetch_ready[%0d]: got %b want 0", tag, i, ready); end
      checks++; if (count !== 3'(model_data.size())) begin errors++; $display("FAIL %s_count[%0d]: got %0d want %0d", tag, i, count, model_data.size()); end
    end
  endtask

  task automatic test_pop3();
    test_pop_n(3, "pop3");
    drive(0, '0, 0);
    checks++; if (empty !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL pop3_end: empty %b ready %b want 1 1", empty, ready); end
  endtask

  task automatic test_replace();
    logic [WIDTH-1:0] ed;
    drive(1, 32'hB0, 0); sb_push(32'hB0);
    drive(1, 32'hB1, 0); sb_push(32'hB1);
    drive(1, 32'hC0, 1);
    ed = model_data.pop_back(); model_data.push_back(32'hC0);
    checks++; if (pop_data !== ed) begin errors++; $display("FAIL repl_data: got %0h want %0h", pop_data, ed); end
    checks++; if (alloc !== 1'b0 || de_alloc !== 1'b0) begin errors++; $display("FAIL repl_handshake: alloc %b de_alloc %b want 0 0", alloc, de_alloc); end
    drive(0, '0, 0);
    checks++; if (count !== 3'd2 || pop_data !== 32'hC0 || ready !== 1'b1) begin
      errors++; $display("FAIL repl_after: count %0d top %0h ready %b want 2 c0 1", count, pop_data, ready); end
    // Push above the replaced node so its rewritten data comes back through the RAM.
    drive(1, 32'hC1, 0); sb_push(32'hC1);
    test_pop_n(3, "repl");
  endtask

  task automatic test_over_under();
    for (int i = 0; i < 4; i++) begin
      drive(1, WIDTH'(32'hD0 + i), 0); sb_push(WIDTH'(32'hD0 + i));
    end
    drive(1, 32'hD4, 0);
    checks++; if (alloc !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL ovf_alloc: alloc %b full %b want 0 1", alloc, full); end
    drive(0, '0, 0);
    checks++; if (overflow !== 1'b1 || count !== 3'd4 || pop_data !== 32'hD3) begin
      errors++; $display("FAIL ovf_pulse: ovf %b count %0d top %0h want 1 4 d3", overflow, count, pop_data); end
    drive(0, '0, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
    test_pop_n(4, "ovf");
    drive(0, '0, 1);
    checks++; if (de_alloc !== 1'b0) begin errors++; $display("FAIL udf_dealloc: got %b want 0", de_alloc); end
    drive(0, '0, 0);
    checks++; if (underflow !== 1'b1 || count !== 3'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL udf_pulse: udf %b count %0d ready %b want 1 0 1", underflow, count, ready); end
    drive(1, 32'hE0, 1);
    checks++; if (alloc !== 1'b1 || de_alloc !== 1'b0) begin errors++; $display("FAIL pp_empty: alloc %b de_alloc %b want 1 0", alloc, de_alloc); end
    sb_push(32'hE0);
    drive(0, '0, 0);
    checks++; if (underflow !== 1'b0 || count !== 3'd1 || pop_data !== 32'hE0) begin
      errors++; $display("FAIL pp_empty_after: udf %b count %0d top %0h want 0 1 e0", underflow, count, pop_data); end
    test_pop_n(1, "pp");
  endtask

  task automatic test_reset_fetch();
    drive(1, 32'hF0, 0); sb_push(32'hF0);
    drive(1, 32'hF1, 0); sb_push(32'hF1);
    drive(0, '0, 1);
    @(negedge clk); push = 1'b0; pop = 1'b0; reset = 1'b1; #1;
    checks++; if (alloc_reset !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL rf_during: alloc_reset %b ready %b want 1 0", alloc_reset, ready); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (count !== 3'd0 || ready !== 1'b0) begin errors++; $display("FAIL rf_rel1: count %0d ready %b want 0 0", count, ready); end
    drive(0, '0, 0);
    checks++; if (count !== 3'd0 || ready !== 1'b0) begin errors++; $display("FAIL rf_rel2: count %0d ready %b want 0 0", count, ready); end
    drive(0, '0, 0);
    checks++; if (ready !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL rf_rel3: ready %b empty %b want 1 1", ready, empty); end
    sb_clear();
  endtask

`ifdef RAS_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive(1, WIDTH'(32'h50 + i), 0);
    @(negedge clk); push = 1'b0; flush = 1'b1; #1;
    checks++; if (alloc_reset !== 1'b1) begin errors++; $display("FAIL fl_alloc_reset: got %b want 1", alloc_reset); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (count !== 3'd0 || ready !== 1'b0 || alloc_reset !== 1'b0) begin
      errors++; $display("FAIL fl_after: count %0d ready %b alloc_reset %b want 0 0 0", count, ready, alloc_reset); end
    drive(0, '0, 0);
    drive(0, '0, 0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b want 1", ready); end
    drive(1, 32'h77, 0);
    checks++; if (alloc !== 1'b1) begin errors++; $display("FAIL fl_push: alloc %b want 1", alloc); end
    drive(0, '0, 0);
    checks++; if (pop_data !== 32'h77 || count !== 3'd1) begin errors++; $display("FAIL fl_top: top %0h count %0d want 77 1", pop_data, count); end
  endtask
`endif

  initial begin
    test_reset();
    test_push3();
    test_pop3();
    test_replace();
    test_over_under();
    test_reset_fetch();
`ifdef RAS_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
